// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bubble encoding,
// PC-redirect select encoding and the opcodes recognised by fetch predecode.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;

  // 2'b11 is reserved and deliberately left unnamed: it falls through as sequential.
  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_TARGET = 2'b01,
    PCSRC_JALR   = 2'b10
  } pcsrc_e;

endpackage

// File: rtl/fetch_predecode.sv
// Static branch predictor: JAL always taken, backward conditional branches
// taken, everything else falls through. Purely combinational.
module fetch_predecode
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  predTaken,
  output logic [ADDR_WIDTH-1:0] predTarget
);

  logic signed [ADDR_WIDTH-1:0] jImm;
  logic signed [ADDR_WIDTH-1:0] bImm;

  assign jImm = {{(ADDR_WIDTH-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                 instr[30:21], 1'b0};
  assign bImm = {{(ADDR_WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                 instr[11:8], 1'b0};

  // Sign bit of the B-immediate is instr[31], so it doubles as the backward flag.
  always_comb begin
    predTaken  = 1'b0;
    predTarget = pc + $unsigned(bImm);
    if (instr[6:0] == OP_JAL) begin
      predTaken  = 1'b1;
      predTarget = pc + $unsigned(jImm);
    end else if (instr[6:0] == OP_BRANCH && instr[31]) begin
      predTaken  = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID register.
// Define FETCH_STATIC_PREDICT_EN to add static branch prediction in fetch.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stallF,
  input  logic                  stallD,
  input  logic                  flushD,
  input  logic [1:0]            PCSrcE,
  input  logic [ADDR_WIDTH-1:0] PCTargetE,
  input  logic [ADDR_WIDTH-1:0] ALUResultE,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instrD,
  output logic [ADDR_WIDTH-1:0] PCD,
  output logic [ADDR_WIDTH-1:0] PCPlus4D,
  output logic                  validD,
  output logic                  predTakenD
);

  logic [ADDR_WIDTH-1:0] pcF;
  logic [ADDR_WIDTH-1:0] pcPlus4F;
  logic [ADDR_WIDTH-1:0] pcNextF;
  logic                  predTakenF;
  pcsrc_e                pcSrc;

`ifdef FETCH_STATIC_PREDICT_EN
  logic [ADDR_WIDTH-1:0] predTargetF;

  fetch_predecode #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) uPredecode (
    .instr     (imem_rdata),
    .pc        (pcF),
    .predTaken (predTakenF),
    .predTarget(predTargetF)
  );
`else
  assign predTakenF = 1'b0;
`endif

  assign imem_addr = pcF;
  assign pcPlus4F  = pcF + ADDR_WIDTH'(4);
  assign pcSrc     = pcsrc_e'(PCSrcE);

  // Redirects outrank stallF: the wrong-path fetch is flushed by the hazard unit anyway.
  always_comb begin
    pcNextF = pcPlus4F;
    if (pcSrc == PCSRC_JALR) begin
      pcNextF = {ALUResultE[ADDR_WIDTH-1:1], 1'b0};
    end else if (pcSrc == PCSRC_TARGET) begin
      pcNextF = PCTargetE;
    end else if (stallF) begin
      pcNextF = pcF;
`ifdef FETCH_STATIC_PREDICT_EN
    end else if (predTakenF) begin
      pcNextF = predTargetF;
`endif
    end
  end

  // ---- IF stage: program counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcF <= RESET_PC;
    end else begin
      pcF <= pcNextF;
    end
  end

  // ---- IF/ID boundary: flush beats stall ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD     <= DATA_WIDTH'(NOP_INSTR);
      PCD        <= '0;
      PCPlus4D   <= '0;
      validD     <= 1'b0;
      predTakenD <= 1'b0;
    end else if (flushD) begin
      instrD     <= DATA_WIDTH'(NOP_INSTR);
      PCD        <= '0;
      PCPlus4D   <= '0;
      validD     <= 1'b0;
      predTakenD <= 1'b0;
    end else if (!stallD) begin
      instrD     <= imem_rdata;
      PCD        <= pcF;
      PCPlus4D   <= pcPlus4F;
      validD     <= 1'b1;
      predTakenD <= predTakenF;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined core. Holds the program counter, drives the instruction-memory address, selects the next PC from sequential, branch-target or JALR redirect sources, and registers the fetched instruction into the IF/ID pipeline register under hazard-unit stall/flush control. Its outputs feed decode (control, regfile read, immediate extension) directly.

## Interface
- DATA_WIDTH, 32, instruction/data word width
- ADDR_WIDTH, 32, PC and instruction address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- stallF  in  1  hold PCF
- stallD  in  1  hold IF/ID register
- flushD  in  1  replace IF/ID contents with bubble
- PCSrcE  in  2  redirect select from EX: 00 none, 01 PCTargetE, 10 ALUResultE (JALR), 11 reserved (treated as 00)
- PCTargetE  in  ADDR_WIDTH  branch/JAL target computed in EX
- ALUResultE  in  ADDR_WIDTH  JALR target computed in EX
- imem_addr  out  ADDR_WIDTH  instruction address (= PCF)
- imem_rdata  in  DATA_WIDTH  instruction word, combinational read of imem_addr
- instrD  out  DATA_WIDTH  registered instruction
- PCD  out  ADDR_WIDTH  registered PC of instrD
- PCPlus4D  out  ADDR_WIDTH  registered PC+4 of instrD
- validD  out  1  instrD is a real fetched instruction (0 = bubble)
- predTakenD  out  1  fetch predicted instrD as taken (see Configuration)

## Operation
- PCF register; imem_addr = PCF; PCPlus4F = PCF + 4 (modulo 2^ADDR_WIDTH, wrap silently).
- Next-PC priority, highest first: PCSrcE=10 -> {ALUResultE[ADDR_WIDTH-1:1],1'b0}; PCSrcE=01 -> PCTargetE; stallF -> PCF; prediction (if enabled and predicted taken) -> predicted target; else PCPlus4F.
- Redirect beats stallF: wrong-path fetch is discarded anyway; the hazard unit asserts flushD with every redirect.
- IF/ID register priority: flushD -> bubble; stallD -> hold; else load {imem_rdata, PCF, PCPlus4F, 1, predTakenF}.
- Bubble: instrD = 32'h0000_0013 (ADDI x0,x0,0), PCD = 0, PCPlus4D = 0, validD = 0, predTakenD = 0.
- flushD with stallD -> bubble (flush wins).
- No alignment checking: PC bits [1:0] pass through except JALR bit 0 clear.

## Timing
- Reset (async assert, immediate): PCF = RESET_PC, IF/ID = bubble. Every output takes its reset value without a clock edge; imem_addr = RESET_PC.
- Reset release is synchronous to next rising edge; first edge after release loads instrD = mem[RESET_PC], validD = 1.
- Fetch latency: 1 cycle from imem_addr to instrD.
- Redirect penalty: PCSrcE sampled at edge N -> imem_addr = target after edge N; target instruction in instrD after edge N+1.
- stallF/stallD assertion of k cycles holds PCF/instrD exactly k edges; no lost or duplicated instruction when both released together.
- Reset asserted mid-stall or mid-redirect discards all pending state.

## Configuration
- FETCH_STATIC_PREDICT_EN defined: predecode imem_rdata in fetch. JAL (opcode 1101111) -> predicted taken, target PCF + J-imm. B-type (1100011) with instr[31]=1 (backward) -> predicted taken, target PCF + B-imm. Otherwise not taken. predTakenF registered into predTakenD; EX uses it to issue a PCSrcE=01 correction (PCPlus4) on mispredict.
- Not defined: no predecode logic; next PC is PCPlus4F when no redirect/stall; predTakenD constant 0.

## Structure
- Shared package fetch_pkg: NOP_INSTR constant, PCSrc encoding enum (PCSRC_SEQ, PCSRC_TARGET, PCSRC_JALR), OP_BRANCH/OP_JAL opcode constants.
- One sub-module, fetch_predecode (combinational: instruction, PC -> predTaken, predTarget), instantiated only under FETCH_STATIC_PREDICT_EN.

## Test plan
- Reset, RESET_PC=0, imem returns word = address: after 3 edges instrD=32'h8, PCD=32'h8, PCPlus4D=32'hC, validD=1.
- stallF=stallD=1 for 2 cycles at PCF=0x10: imem_addr stays 0x10, instrD stays word@0xC; on release next edge instrD=word@0x10.
- PCSrcE=01, PCTargetE=0x100, flushD=1, stallF=1 same cycle: next imem_addr=0x100, instrD=0x13, validD=0; following edge instrD=word@0x100.
- PCSrcE=10, ALUResultE=0x205: next imem_addr=0x204; PCSrcE=11 behaves as sequential.
- flushD=stallD=1 together -> bubble; rst pulsed between edges -> imem_addr=RESET_PC and instrD=0x13 immediately.
- With FETCH_STATIC_PREDICT_EN, BEQ offset -8 at 0x20: next imem_addr=0x18, predTakenD=1; forward BEQ +8 at 0x30 -> 0x34, predTakenD=0; without macro, 0x24 and predTakenD=0.
